// File: rtl/psd_sweep_ctrl.sv
// Frequency-sweep sequencer: programs the DDS, waits to settle, skips one
// PSD average, captures the next and hands it downstream via valid/ready.
module psd_sweep_ctrl #(
    parameter int FW = 32,
    parameter int DW = 36,
    parameter int NW = 10,
    parameter int SW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [FW-1:0] i_f_start,
    input  logic [FW-1:0] i_f_step,
    input  logic [NW-1:0] i_n_points,
    input  logic [SW-1:0] i_settle,
    input  logic [DW-1:0] i_avg_X,
    input  logic [DW-1:0] i_avg_Y,
    input  logic          i_avg_flag,
    output logic [FW-1:0] o_ftw,
    output logic          o_ftw_load,
    output logic [DW-1:0] o_res_X,
    output logic [DW-1:0] o_res_Y,
    output logic [NW-1:0] o_res_idx,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_OUTPUT  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] ftw_q, ftw_d;
    logic [FW-1:0] step_q, step_d;
    logic [NW-1:0] npts_q, npts_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [DW-1:0] resx_q, resx_d;
    logic [DW-1:0] resy_q, resy_d;
    logic [NW-1:0] residx_q, residx_d;
    logic          valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        ftw_d    = ftw_q;
        step_d   = step_q;
        npts_d   = npts_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        resx_d   = resx_q;
        resy_d   = resy_q;
        residx_d = residx_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    step_d   = i_f_step;
                    npts_d   = i_n_points;
                    settle_d = i_settle;
                    idx_d    = '0;
                    if (i_n_points == '0) begin
                        state_d = S_DONE;
                    end else begin
                        ftw_d   = i_f_start;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = settle_q;
                state_d = (settle_q == '0) ? S_DISCARD : S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                // this window may straddle the tuning-word change
                if (i_avg_flag) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (i_avg_flag) begin
                    resx_d   = i_avg_X;
                    resy_d   = i_avg_Y;
                    residx_d = idx_q;
                    valid_d  = 1'b1;
                    state_d  = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (valid_q && i_res_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == npts_q - NW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + NW'(1);
                        ftw_d   = ftw_q + step_q;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            ftw_d   = ftw_q;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ftw_q    <= '0;
            step_q   <= '0;
            npts_q   <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            resx_q   <= '0;
            resy_q   <= '0;
            residx_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ftw_q    <= ftw_d;
            step_q   <= step_d;
            npts_q   <= npts_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            resx_q   <= resx_d;
            resy_q   <= resy_d;
            residx_q <= residx_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ftw       = ftw_q;
    assign o_ftw_load  = (state_q == S_LOAD);
    assign o_res_X     = resx_q;
    assign o_res_Y     = resy_q;
    assign o_res_idx   = residx_q;
    assign o_res_valid = valid_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);

endmodule

// File: doc/psd_sweep_ctrl.md
Name: psd_sweep_ctrl

Overview:
- Sequencer for a frequency sweep of the impedance analyzer.
- Per sweep point it does four things in order:
  - programs the DDS frequency tuning word;
  - waits a settling interval;
  - discards the first PSD average flag (its window may straddle the frequency change);
  - captures the next average's X/Y.
- Captured results are presented to the downstream consumer (UART/host FIFO) through a valid/ready handshake with backpressure.
- Sits between the control registers, the DDS, the free-running PSD averager (128-sample window, one flag per window) and the result path.

Parameters:
- FW, 32, frequency tuning word width.
- DW, 36, PSD X/Y data width.
- NW, 10, point-count and index width.
- SW, 16, settle counter width.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle sweep start; ignored while o_busy=1.
- i_abort  in  1  abort the current sweep; ignored in IDLE.
- i_f_start  in  FW  first tuning word; latched on accepted start.
- i_f_step  in  FW  tuning word increment per point; latched on accepted start.
- i_n_points  in  NW  number of points; latched on accepted start.
- i_settle  in  SW  settle cycles after each tuning-word load; latched on accepted start.
- i_avg_X  in  DW  averager X output (signed).
- i_avg_Y  in  DW  averager Y output (signed).
- i_avg_flag  in  1  one-cycle pulse; i_avg_X/i_avg_Y valid from this cycle until the next flag.
- o_ftw  out  FW  tuning word to the DDS.
- o_ftw_load  out  1  one-cycle DDS load strobe.
- o_res_X  out  DW  captured X.
- o_res_Y  out  DW  captured Y.
- o_res_idx  out  NW  point index of the result, starting at 0.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  consumer ready.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset has priority over everything, including mid-sweep.
- IDLE:
  - When i_start=1: latch the configuration and set idx=0.
  - If i_n_points=0: go to DONE. Otherwise set o_ftw=i_f_start and go to LOAD.
- LOAD:
  - o_ftw_load=1 for exactly this one cycle.
  - Load the settle counter with the latched settle value.
  - Next state is SETTLE; if settle=0, go directly to DISCARD.
- SETTLE:
  - Decrement the counter each cycle.
  - When counter==1, go to DISCARD. The total time in SETTLE is exactly `settle` cycles.
  - Flags arriving in SETTLE are ignored.
- DISCARD: the first i_avg_flag seen in this state is dropped, then go to CAPTURE.
- CAPTURE:
  - On the next i_avg_flag, register i_avg_X/i_avg_Y (same cycle as the flag) into o_res_X/o_res_Y.
  - In the same edge set o_res_idx=idx and o_res_valid=1, then go to OUTPUT.
- OUTPUT:
  - Hold o_res_X, o_res_Y, o_res_idx and o_res_valid stable until i_res_ready=1 while o_res_valid=1.
  - On that handshake edge, clear o_res_valid.
  - If idx==n_points-1: go to DONE. Otherwise idx+=1, o_ftw+=f_step, go to LOAD.
  - Flags arriving in OUTPUT are dropped; there is no buffering.
- DONE: o_done=1 for one cycle, o_busy=0 on the following cycle, return to IDLE.
- o_busy: 1 in every state except IDLE. It is registered and goes high on the edge that accepts the start.
- Abort:
  - In any non-IDLE state, i_abort=1 moves the controller to IDLE on the next edge.
  - o_res_valid clears, o_busy clears, o_done is not pulsed, and o_ftw keeps its last value.
  - If i_abort and the handshake occur in the same cycle, abort wins: the result is treated as consumed and the sweep still ends.
- i_start while busy: ignored. i_start and i_abort together in IDLE: start is accepted.
- Frequency arithmetic: unsigned, modulo 2^FW. Wrap-around is legal and is not flagged.
- Latency: under continuous ready, one point takes 1 (LOAD) + settle + wait to the first flag + 128 + 1 (OUTPUT) cycles.
- Width rules:
  - o_res_idx counts 0..n_points-1.
  - n_points=2^NW-1 is supported; idx never overflows.
- Configuration inputs may change mid-sweep without effect, since only the latched copies are used.

Test Plan:
- n_points=3, f_start=0x1000, f_step=0x0100, settle=20, ready held 1, averager flags every 128 cycles with X=idx*10, Y=-idx → three o_ftw_load pulses carrying 0x1000, 0x1100, 0x1200. Each result comes from the second flag after its settle window. Indices 0,1,2 are output, then o_done pulses once and o_busy falls.
- Backpressure: n_points=2, hold i_res_ready=0 for 500 cycles after the first o_res_valid → o_res_X/Y/idx stay stable and no second o_ftw_load occurs. Raising ready gives one handshake, then the next LOAD.
- Edge configurations:
  - n_points=0 → o_done pulses 2 cycles after start, with no o_ftw_load and no o_res_valid.
  - settle=0 → LOAD is followed directly by DISCARD.
  - f_start=0xFFFFFF80, f_step=0x100 → second o_ftw=0x00000080.
- Abort: assert i_abort during SETTLE of point 1, then again during OUTPUT with ready=1 in the same cycle → IDLE next cycle, o_res_valid=0, o_busy=0, no o_done. A fresh i_start restarts at idx 0.
- Start while busy, then async reset: pulse i_start mid-sweep → ignored and the configuration is unchanged. Assert i_rst asynchronously mid-CAPTURE → all outputs are 0 immediately, and the state is IDLE after release.
